// File: rtl/fifo_sync_param.sv
// Parametrised single-clock FIFO with occupancy status and per-cycle error flag.
// Define FIFO_STICKY_ERR_EN to add ovf_sticky/unf_sticky outputs that hold until reset.
module fifo_sync_param #(
  parameter int WIDTH        = 8,
  parameter int DEPTH        = 8,
  parameter int AFULL_THRESH = DEPTH - 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       wen,
  input  logic                       ren,
  input  logic [WIDTH-1:0]           din,
  output logic [WIDTH-1:0]           dout,
  output logic                       full,
  output logic                       empty,
  output logic                       almost_full,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       error
`ifdef FIFO_STICKY_ERR_EN
  ,
  output logic                       ovf_sticky,
  output logic                       unf_sticky
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT  = (AW+1)'(DEPTH);
  localparam logic [AW:0] AFULL_CNT = (AW+1)'(AFULL_THRESH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr;
  logic [AW-1:0]    rptr;
  logic             rd_ok;
  logic             wr_ok;
  logic             ovf;
  logic             unf;

  always_comb begin
    full        = (count == FULL_CNT);
    empty       = (count == '0);
    almost_full = (count >= AFULL_CNT);
    rd_ok       = ren && !empty;
    // A read in the same cycle frees a slot, so a write to a full FIFO is still accepted.
    wr_ok       = wen && (!full || ren);
    unf         = ren && empty;
    ovf         = wen && full && !ren;
  end

  // Storage has no reset so it can map onto RAM.
  always_ff @(posedge clk) begin
    if (rst_n && wr_ok) begin
      mem[wptr] <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
      dout  <= '0;
      error <= 1'b0;
    end else begin
      error <= unf || ovf;
      if (wr_ok) begin
        wptr <= wptr + 1'b1;
      end
      if (rd_ok) begin
        dout <= mem[rptr];
        rptr <= rptr + 1'b1;
      end
      if (wr_ok && !rd_ok) begin
        count <= count + 1'b1;
      end else if (rd_ok && !wr_ok) begin
        count <= count - 1'b1;
      end
    end
  end

`ifdef FIFO_STICKY_ERR_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ovf_sticky <= 1'b0;
      unf_sticky <= 1'b0;
    end else begin
      if (ovf) ovf_sticky <= 1'b1;
      if (unf) unf_sticky <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_fifo_sync_param.sv
// Directed bench for fifo_sync_param at default size (WIDTH=8, DEPTH=8, AFULL_THRESH=6).
// Covers FIFO_STICKY_ERR_EN outputs when the macro is defined.
module tb_fifo_sync_param;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       wen;
  logic       ren;
  logic [7:0] din;
  logic [7:0] dout;
  logic       full;
  logic       empty;
  logic       almost_full;
  logic [3:0] count;
  logic       error;
`ifdef FIFO_STICKY_ERR_EN
  logic       ovf_sticky;
  logic       unf_sticky;
`endif

  int checks = 0;
  int errors = 0;

  fifo_sync_param #(.WIDTH(8), .DEPTH(8), .AFULL_THRESH(6)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .wen        (wen),
    .ren        (ren),
    .din        (din),
    .dout       (dout),
    .full       (full),
    .empty      (empty),
    .almost_full(almost_full),
    .count      (count),
    .error      (error)
`ifdef FIFO_STICKY_ERR_EN
    ,
    .ovf_sticky (ovf_sticky),
    .unf_sticky (unf_sticky)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of inputs, then sample just after the rising edge.
  task automatic step(input logic r, input logic w, input logic rd, input logic [7:0] d);
    rst_n = r;
    wen   = w;
    ren   = rd;
    din   = d;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    wen   = 1'b0;
    ren   = 1'b0;
    din   = 8'h00;
  endtask

  initial begin
    rst_n = 1'b0; wen = 1'b0; ren = 1'b0; din = 8'h00;
    @(negedge clk);

    // Reset state
    step(1'b0, 1'b0, 1'b0, 8'h00);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_full",  32'(full),  32'd0);
    chk("rst_afull", 32'(almost_full), 32'd0);
    chk("rst_dout",  32'(dout),  32'h00);
    chk("rst_error", 32'(error), 32'd0);

    // Underflow on empty FIFO
    step(1'b1, 1'b0, 1'b1, 8'h00);
    chk("unf_error", 32'(error), 32'd1);
    chk("unf_dout",  32'(dout),  32'h00);
    chk("unf_count", 32'(count), 32'd0);
    step(1'b1, 1'b0, 1'b0, 8'h00);
    chk("unf_error_clr", 32'(error), 32'd0);
`ifdef FIFO_STICKY_ERR_EN
    chk("unf_sticky_set", 32'(unf_sticky), 32'd1);
    chk("ovf_sticky_clr", 32'(ovf_sticky), 32'd0);
`endif

    // Fill with 0x11..0x88
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 1'b1, 1'b0, 8'((i + 1) * 8'h11));
      chk("fill_count", 32'(count), 32'(i + 1));
      chk("fill_afull", 32'(almost_full), (i + 1 >= 6) ? 32'd1 : 32'd0);
      chk("fill_full",  32'(full), (i + 1 == 8) ? 32'd1 : 32'd0);
    end

    // Overflow: rejected, contents untouched
    step(1'b1, 1'b1, 1'b0, 8'h99);
    chk("ovf_error", 32'(error), 32'd1);
    chk("ovf_count", 32'(count), 32'd8);
    chk("ovf_full",  32'(full),  32'd1);
    step(1'b1, 1'b0, 1'b0, 8'h00);
    chk("ovf_error_clr", 32'(error), 32'd0);
`ifdef FIFO_STICKY_ERR_EN
    chk("ovf_sticky_set", 32'(ovf_sticky), 32'd1);
`endif

    // Full with simultaneous read and write
    step(1'b1, 1'b1, 1'b1, 8'hAA);
    chk("fullrw_dout",  32'(dout),  32'h11);
    chk("fullrw_count", 32'(count), 32'd8);
    chk("fullrw_error", 32'(error), 32'd0);

    // Drain: 0x22..0x88 then 0xAA
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 1'b0, 1'b1, 8'h00);
      chk("drain_dout", 32'(dout), (i < 7) ? 32'((i + 2) * 8'h11) : 32'hAA);
      chk("drain_count", 32'(count), 32'(7 - i));
    end
    chk("drain_empty", 32'(empty), 32'd1);

    // Empty with simultaneous read and write
    step(1'b1, 1'b1, 1'b1, 8'h5C);
    chk("emptyrw_error", 32'(error), 32'd1);
    chk("emptyrw_count", 32'(count), 32'd1);
    chk("emptyrw_dout",  32'(dout),  32'hAA);
    step(1'b1, 1'b0, 1'b1, 8'h00);
    chk("emptyrw_read", 32'(dout),  32'h5C);
    chk("emptyrw_err2", 32'(error), 32'd0);
    chk("emptyrw_cnt2", 32'(count), 32'd0);

    // Mid-stream reset discards contents; wen during reset ignored
    for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 1'b0, 8'(i + 1));
    chk("pre_rst_count", 32'(count), 32'd5);
    step(1'b0, 1'b1, 1'b0, 8'hEE);
    chk("midrst_count", 32'(count), 32'd0);
    chk("midrst_empty", 32'(empty), 32'd1);
    chk("midrst_dout",  32'(dout),  32'h00);
`ifdef FIFO_STICKY_ERR_EN
    chk("midrst_ovf_sticky", 32'(ovf_sticky), 32'd0);
    chk("midrst_unf_sticky", 32'(unf_sticky), 32'd0);
`endif
    step(1'b1, 1'b0, 1'b1, 8'h00);
    chk("postrst_unf_error", 32'(error), 32'd1);
    chk("postrst_unf_dout",  32'(dout),  32'h00);

    // Pointer wrap: preload 3, 12 concurrent r/w, drain 3 (15 writes total)
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0, 8'(8'h30 + i));
    for (int j = 0; j < 12; j++) begin
      step(1'b1, 1'b1, 1'b1, 8'(8'h33 + j));
      chk("wrap_dout",  32'(dout),  32'(8'h30 + j));
      chk("wrap_count", 32'(count), 32'd3);
    end
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b0, 1'b1, 8'h00);
      chk("wrap_drain", 32'(dout), 32'(8'h3C + i));
    end
    chk("wrap_empty", 32'(empty), 32'd1);
    chk("wrap_error", 32'(error), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
